load_writeback: RTL
===================

Name: load_writeback

Overview:
- Sequencer between the single-cycle core's load path, data memory and the register-file write port.
- Accepts one load at a time, issues a word-aligned memory read and waits for the response.
- Extracts and extends the addressed byte, halfword or word, then writes it through the register-file write port.
- Also forwards ALU writebacks to that port, stalling the ALU for one cycle when both collide.

Parameters:
- REG_AW, 6, register address width (matches register-file write port).
- TIMEOUT, 255, max WAIT cycles before abort; 8-bit counter, 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted when ld_valid && ld_ready.
- ld_addr  in  32  byte address.
- ld_rd  in  REG_AW  destination register.
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- mem_req  out  1  one-cycle read strobe.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- alu_we  in  1  ALU writeback request.
- alu_rd  in  REG_AW  ALU destination.
- alu_wd  in  32  ALU result.
- alu_stall  out  1  ALU write not taken this cycle; hold and retry.
- rf_we3  out  1  register-file write enable.
- rf_a3  out  REG_AW  register-file write address.
- rf_wd3  out  32  register-file write data.
- busy  out  1  state != IDLE.
- ld_err  out  1  one-cycle pulse on misaligned/illegal/timeout.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; timeout counter=0; captured addr/rd/funct3/data=0.
  - Outputs during reset: mem_req=0, mem_addr=0, ld_err=0, busy=0, ld_ready=1, alu_stall=0.
  - rf_* follow the ALU pass-through rule; rf_we3 is low unless alu_we=1 and alu_rd!=0.
  - Reset mid-operation abandons the load with no write; a late mem_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - ld_ready=1.
  - On ld_valid, capture addr/rd/funct3.
  - Illegal funct3, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: pulse ld_err next cycle, stay IDLE, no memory access, no write.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 for exactly one cycle; mem_addr=word-aligned captured addr.
  - Clear the counter; go to WAIT.
  - mem_addr holds its value until the next REQ.
- WAIT:
  - mem_rvalid is sampled only here; the earliest response is the cycle after mem_req.
  - On mem_rvalid, format and register the data, then go to WB.
  - Otherwise increment the counter; when it reaches TIMEOUT, pulse ld_err and go to IDLE with no write.
  - mem_rvalid outside WAIT is ignored.
- Formatting, using byte lane addr[1:0]:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
- WB:
  - rf_we3=(rd!=0), rf_a3=rd, rf_wd3=formatted data.
  - If alu_we=1 this cycle, alu_stall=1 and the ALU write is not performed.
  - Go to IDLE. ld_ready=0 in WB, so back-to-back loads are spaced by at least 4 cycles.
- All states except WB (ALU pass-through, combinational):
  - rf_we3 = alu_we && alu_rd!=0; rf_a3=alu_rd; rf_wd3=alu_wd; alu_stall=0.
- Register 0: writes to address 0 are never asserted on rf_we3, from either source. The load to x0 still completes its memory access.
- ld_ready=1 only in IDLE. busy=1 in REQ, WAIT and WB.

Test Plan:
- LW at 0x100, rd=5; mem returns 0xDEADBEEF 3 cycles after mem_req -> mem_addr=0x100, one mem_req pulse, then a WB cycle with rf_we3=1, rf_a3=5, rf_wd3=0xDEADBEEF.
- mem_rdata=0x80F07F01 at addr 0x203: LB -> 0xFFFFFF80; LBU -> 0x00000080; LH at 0x202 -> 0xFFFF80F0; LHU at 0x200 -> 0x00007F01.
- LH at 0x101 and funct3=011 -> ld_err pulse, no mem_req, no rf_we3, ld_ready stays 1.
- mem_rvalid never asserted, TIMEOUT=4 -> ld_err pulse, return to IDLE, no write.
- alu_we=1, rd=7, data 0x1234 during the WB cycle of a load to rd=3 -> alu_stall=1 and rf_a3=3; next cycle, ALU retry writes rd=7 with 0x1234.
- Load to rd=0 completes with no rf_we3. ALU write to rd=0 gives no rf_we3. reset_n dropped in WAIT, then mem_rvalid after release -> state IDLE, no write.

Source files
------------

// File: rtl/load_writeback.sv
// Load sequencer between the core load path, data memory and the register-file
// write port; also forwards ALU writebacks, stalling the ALU when a load writes.
module load_writeback #(
    parameter int unsigned REG_AW  = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [2:0]        ld_funct3,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              alu_we,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [31:0]       alu_wd,
    output logic              alu_stall,
    output logic              rf_we3,
    output logic [REG_AW-1:0] rf_a3,
    output logic [31:0]       rf_wd3,
    output logic              busy,
    output logic              ld_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        r_lane;
    logic [1:0]        w_lane_nxt;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] w_rd_nxt;
    logic [2:0]        r_funct3;
    logic [2:0]        w_funct3_nxt;
    logic [31:0]       r_data;
    logic [31:0]       w_data_nxt;
    logic [31:0]       r_mem_addr;
    logic [31:0]       w_mem_addr_nxt;
    logic              r_ld_err;
    logic              w_ld_err_nxt;

    // Legal opcode with natural alignment for its access size.
    function automatic logic f_legal(input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~lane[0];
            F3_LW:         ok = (lane == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Lane select plus sign/zero extension of the returned word.
    function automatic logic [31:0] f_format(input logic [2:0]  f3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] word);
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        logic [31:0] res;
        case (lane)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  res = {24'h0, w_byte};
            F3_LH:   res = {{16{w_half[15]}}, w_half};
            F3_LHU:  res = {16'h0, w_half};
            default: res = word;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_data     <= '0;
            r_mem_addr <= '0;
            r_ld_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lane     <= w_lane_nxt;
            r_rd       <= w_rd_nxt;
            r_funct3   <= w_funct3_nxt;
            r_data     <= w_data_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_ld_err   <= w_ld_err_nxt;
        end
    end

    // Next-state and captured-data logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_lane_nxt     = r_lane;
        w_rd_nxt       = r_rd;
        w_funct3_nxt   = r_funct3;
        w_data_nxt     = r_data;
        w_mem_addr_nxt = r_mem_addr;
        w_ld_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ld_valid) begin
                    w_lane_nxt   = ld_addr[1:0];
                    w_rd_nxt     = ld_rd;
                    w_funct3_nxt = ld_funct3;
                    if (f_legal(ld_funct3, ld_addr[1:0])) begin
                        w_state_nxt    = S_REQ;
                        w_mem_addr_nxt = {ld_addr[31:2], 2'b00};
                    end else begin
                        w_ld_err_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_data_nxt  = f_format(r_funct3, r_lane, mem_rdata);
                    w_state_nxt = S_WB;
                end else if (r_cnt == CNT_LAST) begin
                    w_ld_err_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write-port arbitration: the load owns the port in WB, the ALU otherwise.
    always_comb begin
        ld_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        mem_req   = (r_state == S_REQ);
        mem_addr  = r_mem_addr;
        ld_err    = r_ld_err;
        rf_we3    = alu_we && (alu_rd != '0);
        rf_a3     = alu_rd;
        rf_wd3    = alu_wd;
        alu_stall = 1'b0;
        if (r_state == S_WB) begin
            rf_we3    = (r_rd != '0);
            rf_a3     = r_rd;
            rf_wd3    = r_data;
            alu_stall = alu_we;
        end
    end

endmodule
